// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEF_DEPTH_WORDS = 256;
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = be[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return m;
  endfunction
endpackage

// File: rtl/dmem_responder_bram_be.sv
// bram_be: byte-enable RAM, synchronous write, combinational read, no reset
//   clk clock | i_we write strobe | i_addr word index | i_wdata/i_be write data and lanes | o_rdata read word
module bram_be #(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (i_we && i_be[i]) r_mem[i_addr][8*i+:8] <= i_wdata[8*i+:8];
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store target with programmable wait states and valid/ready request/response
//   clk, reset_n (async, active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be : request handshake and payload
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                 : response handshake and payload
//   mon_we/mon_addr/mon_wdata                             : one-cycle store-commit monitor
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mon_we,
  output logic [31:0] mon_addr,
  output logic [31:0] mon_wdata
);
  localparam int IDX_W = idx_width(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_mon_we;
  logic [31:0] r_mon_addr, r_mon_wdata;
  logic        w_idle, w_accept, w_access, w_we, w_err;
  logic [31:0] w_addr, w_wdata, w_off, w_rdata, w_merged;
  logic [3:0]  w_be;
  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && req_valid;
  // With no wait states the access happens on the accept edge, so the live inputs feed the datapath.
  assign w_access = (w_accept && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == 4'd0);
  assign w_we     = w_idle ? req_we    : r_we;
  assign w_addr   = w_idle ? req_addr  : r_addr;
  assign w_wdata  = w_idle ? req_wdata : r_wdata;
  assign w_be     = w_idle ? req_be    : r_be;
  assign w_off    = w_addr - BASE_ADDR;
  // Compare against a 33-bit span so a region ending at 2^32 does not overflow.
  assign w_err    = (w_addr[1:0] != 2'b00) || (w_addr < BASE_ADDR) || ({1'b0, w_off} >= SPAN);
  assign w_merged = be_merge(w_rdata, w_wdata, w_be);
  bram_be #(.DEPTH(DEPTH_WORDS), .AW(IDX_W)) u_ram (
    .clk    (clk),
    .i_we   (w_access && w_we && !w_err),
    .i_addr (w_off[IDX_W+1:2]),
    .i_wdata(w_wdata),
    .i_be   (w_be),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next    = r_state;
    req_ready = w_idle && reset_n;
    rsp_valid = (r_state == RESP);
    case (r_state)
      IDLE:    w_next = req_valid ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
      WAIT:    w_next = (r_cnt == 4'd0) ? RESP : WAIT;
      RESP:    w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mon_we    <= 1'b0;
      r_mon_addr  <= '0;
      r_mon_wdata <= '0;
    end else begin
      r_mon_we <= 1'b0;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= CNT_INIT;
      end else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_access) begin
        r_rdata <= (w_we || w_err) ? 32'd0 : w_rdata;
        r_err   <= w_err;
        if (w_we && !w_err) begin
          r_mon_we    <= 1'b1;
          r_mon_addr  <= w_addr;
          r_mon_wdata <= w_merged;
        end
      end
    end
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign mon_we    = r_mon_we;
  assign mon_addr  = r_mon_addr;
  assign mon_wdata = r_mon_wdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with 2 and 0 wait states
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, mon_we;
  logic [31:0] req_addr, req_wdata, rsp_rdata, mon_addr, mon_wdata;
  logic [3:0] req_be;
  logic z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err, z_mon_we;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata, z_mon_addr, z_mon_wdata;
  logic [3:0] z_req_be;
  int tests = 0;
  int fails = 0;
  logic [31:0] rd, ma, md;
  logic e, mw;
  int lat;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mon_we(mon_we), .mon_addr(mon_addr), .mon_wdata(mon_wdata)
  );
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
    .mon_we(z_mon_we), .mon_addr(z_mon_addr), .mon_wdata(z_mon_wdata)
  );

  // Present one request to u0 (assumed idle) for a single edge, then scramble the inputs.
  task automatic accept(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
  endtask

  // Wait (bounded) for u0's response, snapshot it with the monitor, then complete the handshake.
  task automatic finish_rsp(output logic [31:0] o_rd, output logic o_e, output logic o_mw,
                            output logic [31:0] o_ma, output logic [31:0] o_md, output int o_lat);
    o_lat = 0;
    while (!rsp_valid && o_lat < 40) begin @(posedge clk); #1; o_lat++; end
    if (!rsp_valid) o_lat = -1;
    o_rd = rsp_rdata; o_e = rsp_err; o_mw = mon_we; o_ma = mon_addr; o_md = mon_wdata;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
    z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_wdata = 0; z_req_be = 0; z_rsp_ready = 1;
    repeat (2) @(posedge clk); #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    tests++; if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp got %h/%b exp 0/0", rsp_rdata, rsp_err); end
    tests++; if (mon_we !== 1'b0 || mon_addr !== 32'd0 || mon_wdata !== 32'd0) begin fails++; $display("FAIL reset_mon got %b/%h/%h exp 0/0/0", mon_we, mon_addr, mon_wdata); end
    reset_n = 1'b1; #1;
    tests++; if (req_ready !== 1'b1 || z_req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b/%b exp 1/1", req_ready, z_req_ready); end
  endtask

  task automatic test_store_load;
    accept(1'b1, 32'd100, 32'd25, 4'hF);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL store_latency got %0d exp 2", lat); end
    tests++; if (mw !== 1'b1 || ma !== 32'd100 || md !== 32'd25) begin fails++; $display("FAIL store_mon got %b/%0d/%0d exp 1/100/25", mw, ma, md); end
    tests++; if (e !== 1'b0 || rd !== 32'd0) begin fails++; $display("FAIL store_rsp got err %b rdata %h exp 0/0", e, rd); end
    tests++; if (mon_we !== 1'b0) begin fails++; $display("FAIL store_mon_pulse got %b exp 0", mon_we); end
    accept(1'b0, 32'd100, 32'd0, 4'h0);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (rd !== 32'd25 || e !== 1'b0 || mw !== 1'b0) begin fails++; $display("FAIL load_100 got %h/%b/%b exp 19/0/0", rd, e, mw); end
  endtask

  task automatic test_byte_merge;
    accept(1'b1, 32'd96, 32'hAABBCCDD, 4'hF);
    finish_rsp(rd, e, mw, ma, md, lat);
    accept(1'b1, 32'd96, 32'h11223344, 4'b0101);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (mw !== 1'b1 || md !== 32'hAA22CC44) begin fails++; $display("FAIL merge_mon got %b/%h exp 1/aa22cc44", mw, md); end
    accept(1'b1, 32'd96, 32'hFFFFFFFF, 4'b0000);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (mw !== 1'b1 || md !== 32'hAA22CC44 || e !== 1'b0) begin fails++; $display("FAIL be0_mon got %b/%h/%b exp 1/aa22cc44/0", mw, md, e); end
    accept(1'b0, 32'd96, 32'd0, 4'h0);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (rd !== 32'hAA22CC44) begin fails++; $display("FAIL merge_load got %h exp aa22cc44", rd); end
  endtask

  task automatic test_errors;
    accept(1'b0, 32'd102, 32'd0, 4'h0);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (e !== 1'b1 || rd !== 32'd0 || mw !== 1'b0) begin fails++; $display("FAIL misaligned_load got %b/%h/%b exp 1/0/0", e, rd, mw); end
    accept(1'b1, 32'd0, 32'h55, 4'hF);
    finish_rsp(rd, e, mw, ma, md, lat);
    accept(1'b1, 32'd1024, 32'hDEAD, 4'hF);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (e !== 1'b1 || mw !== 1'b0 || rd !== 32'd0) begin fails++; $display("FAIL range_store got %b/%b/%h exp 1/0/0", e, mw, rd); end
    accept(1'b0, 32'd1024, 32'd0, 4'h0);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (e !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL range_load got %b/%h exp 1/0", e, rd); end
    accept(1'b1, 32'd98, 32'hFFFFFFFF, 4'hF);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (e !== 1'b1 || mw !== 1'b0) begin fails++; $display("FAIL misaligned_store got %b/%b exp 1/0", e, mw); end
    accept(1'b0, 32'd0, 32'd0, 4'h0);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (rd !== 32'h55 || e !== 1'b0) begin fails++; $display("FAIL word0_intact got %h/%b exp 55/0", rd, e); end
    accept(1'b0, 32'd96, 32'd0, 4'h0);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (rd !== 32'hAA22CC44) begin fails++; $display("FAIL word96_intact got %h exp aa22cc44", rd); end
  endtask

  task automatic test_backpressure;
    int n;
    accept(1'b0, 32'd100, 32'd0, 4'h0);
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_rsp_timeout got %b exp 1", rsp_valid); end
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd100; req_wdata = 32'd0; req_be = 4'hF;
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd25 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold_%0d got v%b d%h e%b r%b exp v1 d19 e0 r0", i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL bp_release got v%b r%b exp v0 r1", rsp_valid, req_ready); end
    accept(1'b0, 32'd100, 32'd0, 4'h0);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (rd !== 32'd25) begin fails++; $display("FAIL bp_no_store got %h exp 19", rd); end
  endtask

  task automatic test_back_to_back;
    int last, n;
    logic acc;
    last = -1; n = 0;
    z_rsp_ready = 1'b1; z_req_we = 1'b1; z_req_addr = 32'd8; z_req_be = 4'hF; z_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      z_req_wdata = 32'(i);
      acc = z_req_ready;
      @(posedge clk); #1;
      if (acc) begin
        tests++;
        if (z_rsp_valid !== 1'b1 || z_mon_we !== 1'b1 || z_mon_wdata !== 32'(i)) begin
          fails++; $display("FAIL b2b_rsp_%0d got v%b m%b d%h exp v1 m1 d%h", i, z_rsp_valid, z_mon_we, z_mon_wdata, 32'(i));
        end
        if (last >= 0) begin
          tests++; if (i - last != 2) begin fails++; $display("FAIL b2b_spacing got %0d exp 2", i - last); end
        end
        last = i; n++;
      end else begin
        tests++; if (z_rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle_%0d got %b exp 0", i, z_rsp_valid); end
      end
    end
    z_req_valid = 1'b0;
    tests++; if (n != 5) begin fails++; $display("FAIL b2b_accepts got %0d exp 5", n); end
    z_req_we = 1'b0; z_req_valid = 1'b1;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    tests++; if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'd8 || z_rsp_err !== 1'b0) begin fails++; $display("FAIL b2b_load got v%b d%h e%b exp v1 d8 e0", z_rsp_valid, z_rsp_rdata, z_rsp_err); end
    @(posedge clk); #1;
    tests++; if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin fails++; $display("FAIL b2b_done got v%b r%b exp v0 r1", z_rsp_valid, z_req_ready); end
  endtask

  task automatic test_reset_mid;
    accept(1'b1, 32'd64, 32'h12345678, 4'hF);
    finish_rsp(rd, e, mw, ma, md, lat);
    accept(1'b1, 32'd64, 32'hFFFFFFFF, 4'hF);
    reset_n = 1'b0; #1;
    tests++; if (rsp_valid !== 1'b0 || mon_we !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL midrst_ctrl got v%b m%b r%b exp 0/0/0", rsp_valid, mon_we, req_ready); end
    tests++; if (mon_addr !== 32'd0 || mon_wdata !== 32'd0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin fails++; $display("FAIL midrst_data got %h/%h/%h/%b exp 0/0/0/0", mon_addr, mon_wdata, rsp_rdata, rsp_err); end
    repeat (3) @(posedge clk); #1;
    tests++; if (mon_we !== 1'b0) begin fails++; $display("FAIL midrst_no_commit got %b exp 0", mon_we); end
    reset_n = 1'b1; #1;
    accept(1'b0, 32'd64, 32'd0, 4'h0);
    finish_rsp(rd, e, mw, ma, md, lat);
    tests++; if (rd !== 32'h12345678 || e !== 1'b0) begin fails++; $display("FAIL midrst_old_value got %h/%b exp 12345678/0", rd, e); end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_byte_merge;
    test_errors;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
